// File: rtl/sr_reg_dump_pkg.sv
// Shared widths, beat record and FSM encoding for the register dump engine.
// The CSUM state only exists when SR_REG_DUMP_CHECKSUM_EN is defined.
package sr_reg_dump_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
`ifdef SR_REG_DUMP_CHECKSUM_EN
    , CSUM = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } beat_t;
endpackage

// File: rtl/sr_dump_csum.sv
// Running XOR accumulator over transferred dump beats; clear wins over enable.
module sr_dump_csum
  import sr_reg_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] csum
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     csum <= '0;
    else if (clr) csum <= '0;
    else if (en)  csum <= csum ^ din;
  end
endmodule

// File: rtl/sr_reg_dump.sv
// Walks CPU debug registers FIRST_REG..LAST_REG and streams them out as valid/ready beats.
// Define SR_REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module sr_reg_dump
  import sr_reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [REG_ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0]     regData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  out_csum,
  output logic                  busy,
  output logic                  done
);
  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  state_t                state, state_nxt;
  logic [REG_ADDR_W-1:0] addr_q, addr_nxt;
  beat_t                 beat_q, beat_nxt;
  logic                  done_q, done_nxt;
  logic                  at_last;

`ifdef SR_REG_DUMP_CHECKSUM_EN
  logic              csum_clr, csum_en;
  logic [DATA_W-1:0] csum;

  sr_dump_csum u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (csum_clr),
    .en   (csum_en),
    .din  (beat_q.data),
    .csum (csum)
  );
`endif

  assign at_last = (addr_q == LAST_A);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    beat_nxt  = beat_q;
    done_nxt  = 1'b0;
`ifdef SR_REG_DUMP_CHECKSUM_EN
    csum_clr  = 1'b0;
    csum_en   = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin
        state_nxt = READ;
        addr_nxt  = FIRST_A;
`ifdef SR_REG_DUMP_CHECKSUM_EN
        csum_clr  = 1'b1;
`endif
      end
      READ: begin
        beat_nxt.data = regData;
        beat_nxt.addr = addr_q;
        state_nxt     = SEND;
      end
      SEND: if (out_ready) begin
`ifdef SR_REG_DUMP_CHECKSUM_EN
        csum_en = 1'b1;
`endif
        if (!at_last) begin
          addr_nxt  = addr_q + 1'b1;
          state_nxt = READ;
        end else begin
`ifdef SR_REG_DUMP_CHECKSUM_EN
          // The accumulator has not yet folded in this beat, so fold it here.
          state_nxt     = CSUM;
          beat_nxt.addr = '0;
          beat_nxt.data = csum ^ beat_q.data;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end
      end
`ifdef SR_REG_DUMP_CHECKSUM_EN
      CSUM: if (out_ready) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      beat_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      beat_q <= beat_nxt;
      done_q <= done_nxt;
    end
  end

  assign regAddr  = addr_q;
  assign out_addr = beat_q.addr;
  assign out_data = beat_q.data;
  assign busy     = (state != IDLE);
  assign done     = done_q;

`ifdef SR_REG_DUMP_CHECKSUM_EN
  assign out_valid = (state == SEND) || (state == CSUM);
  assign out_last  = (state == CSUM);
  assign out_csum  = (state == CSUM);
`else
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (beat_q.addr == LAST_A);
  assign out_csum  = 1'b0;
`endif
endmodule

// File: tb/tb_sr_reg_dump.sv
// Self-checking bench for sr_reg_dump: transaction model plus directed literal scenarios.
module tb_sr_reg_dump;
  import sr_reg_dump_pkg::*;
`ifdef SR_REG_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int FR = 0, LR = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // main instance (default parameters)
  logic        start = 1'b0, ready = 1'b1;
  logic [4:0]  reg_addr, oa;
  logic [31:0] reg_data, od;
  logic        ov, ol, oc, busy, done;
  logic [31:0] mem [32];
  assign reg_data = mem[reg_addr];

  sr_reg_dump u_dut (
    .clk(clk), .rst(rst), .start(start), .regAddr(reg_addr), .regData(reg_data),
    .out_valid(ov), .out_ready(ready), .out_addr(oa), .out_data(od),
    .out_last(ol), .out_csum(oc), .busy(busy), .done(done)
  );

  // aux instances: [0] single register 7, [1] registers 1..3 with data 1,2,4
  logic [1:0]  a_start = 2'b00;
  logic [4:0]  a_ra [2];
  logic [31:0] a_rd [2];
  logic        a_v [2], a_l [2], a_c [2], a_b [2], a_d [2];
  logic [4:0]  a_a [2];
  logic [31:0] a_o [2];
  assign a_rd[0] = 32'hA000_0000 | {27'd0, a_ra[0]};
  assign a_rd[1] = 32'd1 << (a_ra[1] - 5'd1);

  sr_reg_dump #(.FIRST_REG(7), .LAST_REG(7)) u_one (
    .clk(clk), .rst(rst), .start(a_start[0]), .regAddr(a_ra[0]), .regData(a_rd[0]),
    .out_valid(a_v[0]), .out_ready(1'b1), .out_addr(a_a[0]), .out_data(a_o[0]),
    .out_last(a_l[0]), .out_csum(a_c[0]), .busy(a_b[0]), .done(a_d[0])
  );
  sr_reg_dump #(.FIRST_REG(1), .LAST_REG(3)) u_small (
    .clk(clk), .rst(rst), .start(a_start[1]), .regAddr(a_ra[1]), .regData(a_rd[1]),
    .out_valid(a_v[1]), .out_ready(1'b1), .out_addr(a_a[1]), .out_data(a_o[1]),
    .out_last(a_l[1]), .out_csum(a_c[1]), .busy(a_b[1]), .done(a_d[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a dump is a list of beats, each sampled from mem one cycle after its address is issued.
  bit          m_busy, m_pres, m_cbeat, m_done, m_last;
  int          m_ptr;
  logic [4:0]  m_oa;
  logic [31:0] m_od, m_x;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_pres <= 0; m_cbeat <= 0; m_done <= 0; m_last <= 0;
      m_ptr <= 0; m_oa <= '0; m_od <= '0; m_x <= '0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1; m_pres <= 0; m_cbeat <= 0; m_ptr <= FR; m_x <= '0;
        end
      end else if (!m_pres) begin
        m_pres <= 1; m_oa <= 5'(m_ptr); m_od <= mem[m_ptr];
        m_last <= (m_ptr == LR) && !CS;
      end else if (ready) begin
        if (m_cbeat) begin
          m_busy <= 0; m_pres <= 0; m_cbeat <= 0; m_done <= 1;
        end else if (m_ptr == LR) begin
          if (CS) begin
            m_cbeat <= 1; m_od <= m_x ^ m_od; m_oa <= '0; m_last <= 1; m_x <= m_x ^ m_od;
          end else begin
            m_busy <= 0; m_pres <= 0; m_done <= 1;
          end
        end else begin
          m_x <= m_x ^ m_od; m_ptr <= m_ptr + 1; m_pres <= 0;
        end
      end
    end
  end

  always @(negedge clk) if (rst) begin
    chk("out_valid", 32'(ov), 32'(m_pres));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("regAddr", 32'(reg_addr), 32'(m_ptr));
    if (m_pres) begin
      chk("out_addr", 32'(oa), 32'(m_oa));
      chk("out_data", od, m_od);
      chk("out_last", 32'(ol), 32'(m_last));
      chk("out_csum", 32'(oc), 32'(m_cbeat));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(ov), 0);
    chk({tag, "_addr"}, 32'(oa), 0);
    chk({tag, "_data"}, od, 0);
    chk({tag, "_last"}, 32'(ol), 0);
    chk({tag, "_csum"}, 32'(oc), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_regAddr"}, 32'(reg_addr), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    for (c = 0; c < 400 && busy; c++) @(negedge clk);
    chk({tag, "_finished"}, 32'(busy), 0);
  endtask

  task automatic wait_beat(input logic [4:0] addr, input string tag);
    bit found = 0;
    for (int c = 0; c < 200; c++) begin
      if (ov && oa == addr) begin found = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_beat_seen"}, 32'(found), 1);
  endtask

  logic [31:0] ad [8];
  logic [4:0]  aa [8];
  logic        al [8], ac [8];
  int          anb;
  bit          adone;
  task automatic run_aux(input int k);
    anb = 0; adone = 0;
    @(negedge clk); a_start[k] = 1'b1;
    @(negedge clk); a_start[k] = 1'b0;
    for (int c = 0; c < 30 && !adone; c++) begin
      if (a_d[k]) adone = 1;
      if (a_v[k] && anb < 8) begin
        ad[anb] = a_o[k]; aa[anb] = a_a[k]; al[anb] = a_l[k]; ac[anb] = a_c[k]; anb++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, bcnt, dcyc, lcyc;
    logic [31:0] b0d, b31d;
    logic [4:0]  b0a;
    logic        b31l;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h0000_0040;

    #1 rst = 1'b0;
    #2 chk_zero("reset");
    #9 rst = 1'b1;

    // full default dump, always ready
    pulse_start();
    nb = 0; bcnt = 0; dcyc = -1; lcyc = -1; b0d = '0; b0a = '1; b31d = '0; b31l = 1'b0;
    for (int c = 0; c < 200 && dcyc < 0; c++) begin
      if (busy) bcnt++;
      if (done) dcyc = c;
      if (ov && ready) begin
        if (nb == 0) begin b0d = od; b0a = oa; end
        if (oa == 5'd31 && !oc) begin b31d = od; b31l = ol; end
        if (ol) lcyc = c;
        nb++;
      end
      @(negedge clk);
    end
    chk("full_done_seen", 32'(dcyc >= 0), 1);
    chk("full_beats", 32'(nb), 32'(32 + int'(CS)));
    chk("full_beat0_addr", 32'(b0a), 0);
    chk("full_beat0_data", b0d, 32'h0000_0040);
    chk("full_beat31_data", b31d, 32'hA000_001F);
    chk("full_beat31_last", 32'(b31l), 32'(!CS));
    chk("full_busy_cycles", 32'(bcnt), 32'(64 + int'(CS)));
    chk("full_done_after_last", 32'(dcyc), 32'(lcyc + 1));

    // backpressure on beat 3 while the CPU changes register 3
    pulse_start();
    wait_beat(5'd3, "stall");
    ready = 1'b0;
    mem[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", od, 32'hA000_0003);
      chk("stall_regAddr", 32'(reg_addr), 3);
      chk("stall_valid", 32'(ov), 1);
    end
    ready = 1'b1;
    wait_idle("stall");

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 15) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 31)] = $urandom;
    end
    @(negedge clk); start = 1'b0; ready = 1'b1;
    wait_idle("random");

    // start while busy, then reset during beat 10
    pulse_start();
    wait_beat(5'd10, "abort");
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start_ignored", 32'(reg_addr), 11);
    #2 rst = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resume_busy", 32'(busy), 0);
      chk("no_resume_valid", 32'(ov), 0);
    end
    pulse_start();
    chk("restart_regAddr", 32'(reg_addr), FR);
    chk("restart_busy", 32'(busy), 1);
    wait_idle("restart");

    // single-register dump
    run_aux(0);
    chk("one_done", 32'(adone), 1);
    chk("one_beats", 32'(anb), 32'(1 + int'(CS)));
    chk("one_addr", 32'(aa[0]), 7);
    chk("one_data", ad[0], 32'hA000_0007);
    chk("one_last", 32'(al[0]), 32'(!CS));
    if (CS) begin
      chk("one_csum_data", ad[1], 32'hA000_0007);
      chk("one_csum_flag", 32'(ac[1]), 1);
    end

    // registers 1..3 holding 1,2,4
    run_aux(1);
    chk("small_done", 32'(adone), 1);
    chk("small_beats", 32'(anb), 32'(3 + int'(CS)));
    for (int i = 0; i < 3; i++) begin
      chk("small_addr", 32'(aa[i]), 32'(i + 1));
      chk("small_data", ad[i], 32'd1 << i);
      chk("small_last", 32'(al[i]), 32'(!CS && i == 2));
      chk("small_csum_flag", 32'(ac[i]), 0);
    end
    if (CS) begin
      chk("small_csum_data", ad[3], 32'h0000_0007);
      chk("small_csum_addr", 32'(aa[3]), 0);
      chk("small_csum_last", 32'(al[3]), 1);
      chk("small_csum_beat", 32'(ac[3]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
